// File: rtl/spi_slave_port.sv
// SPI mode-0 responder: oversamples the SPI pins in the BOARD_CLOCK domain and
// exchanges WIDTH-bit words MSB first, back-to-back under a single chip select.
module spi_slave_port #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             BOARD_CLOCK,
    input  logic             RST_N,
    input  logic             SPI_CLK,
    input  logic             SPI_CS_N,
    input  logic             SPI_MOSI,
    output logic             SPI_MISO,
    output logic             SPI_MISO_OE,
    input  logic [WIDTH-1:0] SPI_I,
    output logic [WIDTH-1:0] SPI_O,
    output logic             SPI_DONE_O,
    output logic             SPI_ABORT_O,
    output logic             SPI_BUSY_O
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   cs_hist_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] word_q;
    logic             miso_q;
    logic             oe_q;
    logic             done_q;
    logic             abort_q;
    logic             busy_q;

    // Pin synchronisers plus one history flop for edge detection; presets match an idle bus.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge strobes from the last sync stage against its history flop.
    always_comb begin
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_hist_q;
        sclk_fall = ~sclk_s & sclk_hist_q;
        cs_rise   = cs_s & ~cs_hist_q;
        cs_fall   = ~cs_s & cs_hist_q;
    end

    // Transfer FSM; a CS release outranks any SCLK edge seen in the same cycle.
    always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            word_q  <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        tx_q    <= SPI_I;
                        miso_q  <= SPI_I[WIDTH-1];
                        oe_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // A word completed just before release is still delivered.
                        if (cnt_q == CNT_FULL) begin
                            word_q <= rx_q;
                            done_q <= 1'b1;
                        end else if (cnt_q != '0) begin
                            abort_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        miso_q  <= 1'b0;
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_FULL) begin
                        word_q <= rx_q;
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                    end else if (sclk_rise) begin
                        rx_q  <= {rx_q[WIDTH-2:0], mosi_s};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (sclk_fall) begin
                        if (cnt_q != '0) begin
                            tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
                            miso_q <= tx_q[WIDTH-2];
                        end else begin
                            // Word boundary: fetch the next word for back-to-back transfers.
                            tx_q   <= SPI_I;
                            miso_q <= SPI_I[WIDTH-1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_OE = oe_q;
    assign SPI_O       = word_q;
    assign SPI_DONE_O  = done_q;
    assign SPI_ABORT_O = abort_q;
    assign SPI_BUSY_O  = busy_q;

endmodule
